// File: rtl/btn_deb_multi_sv.sv
`default_nettype none
// ============================================================================
// Module   : btn_deb_multi_sv
// Purpose  : Multi-channel button debouncer with press/release/long-press
//            pulses. Define BTN_DEB_REPEAT_EN to enable auto-repeat pulses.
// Revision : 1.0 - initial release
// ============================================================================
module btn_deb_multi_sv #(
    parameter int   NUM_BTN         = 4,
    parameter int   DEB_CNT         = 1000000,
    parameter logic ACTIVE_HIGH_BTN = 1'b1,
    parameter int   LONG_CNT        = 40000000,
    parameter int   REPEAT_CNT      = 8000000
) (
    input  logic               i_sysclk_40,
    input  logic               i_rst,
    input  logic [NUM_BTN-1:0] i_btn,
    output logic [NUM_BTN-1:0] o_level,
    output logic [NUM_BTN-1:0] o_press,
    output logic [NUM_BTN-1:0] o_release,
    output logic [NUM_BTN-1:0] o_long,
    output logic [NUM_BTN-1:0] o_repeat
);

    localparam int DEB_W    = $clog2(DEB_CNT + 1);
    // One counter serves as hold timer in PRESSED and as repeat timer in LONG.
    localparam int HOLD_MAX = (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [DEB_W-1:0]  C_DEB_LAST  = DEB_W'(DEB_CNT - 1);
    localparam logic [HOLD_W-1:0] C_LONG_LAST = HOLD_W'(LONG_CNT - 1);
`ifdef BTN_DEB_REPEAT_EN
    localparam logic [HOLD_W-1:0] C_REP_LAST  = HOLD_W'(REPEAT_CNT - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_LONG    = 2'd2
    } state_t;

    logic [NUM_BTN-1:0] w_btn_n;
    assign w_btn_n = i_btn ^ {NUM_BTN{~ACTIVE_HIGH_BTN}};

    for (genvar n = 0; n < NUM_BTN; n++) begin : g_ch
        logic [1:0]        r_sync;
        logic [DEB_W-1:0]  r_deb;
        logic [HOLD_W-1:0] r_hold;
        state_t            r_state;
        logic              r_level;
        logic              r_press;
        logic              r_release;
        logic              r_long;
        logic              w_accept;
        logic              w_rise;
        logic              w_fall;
`ifdef BTN_DEB_REPEAT_EN
        logic              r_repeat;
`endif

        assign w_accept = (r_sync[1] != r_level) && (r_deb == C_DEB_LAST);
        assign w_rise   = w_accept & ~r_level;
        assign w_fall   = w_accept &  r_level;

        always_ff @(posedge i_sysclk_40 or posedge i_rst) begin
            if (i_rst) begin
                r_sync    <= 2'b00;
                r_deb     <= '0;
                r_hold    <= '0;
                r_state   <= S_IDLE;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_long    <= 1'b0;
`ifdef BTN_DEB_REPEAT_EN
                r_repeat  <= 1'b0;
`endif
            end else begin
                r_sync    <= {r_sync[0], w_btn_n[n]};
                r_press   <= w_rise;
                r_release <= w_fall;
                r_long    <= 1'b0;
`ifdef BTN_DEB_REPEAT_EN
                r_repeat  <= 1'b0;
`endif
                if (r_sync[1] == r_level || w_accept) begin
                    r_deb <= '0;
                end else begin
                    r_deb <= r_deb + 1'b1;
                end
                if (w_accept) begin
                    r_level <= ~r_level;
                end

                case (r_state)
                    S_IDLE: begin
                        if (w_rise) begin
                            r_state <= S_PRESSED;
                            r_hold  <= '0;
                        end
                    end
                    S_PRESSED: begin
                        // A release on the long-press edge takes priority.
                        if (w_fall) begin
                            r_state <= S_IDLE;
                        end else if (r_hold == C_LONG_LAST) begin
                            r_state <= S_LONG;
                            r_long  <= 1'b1;
                            r_hold  <= '0;
                        end else begin
                            r_hold  <= r_hold + 1'b1;
                        end
                    end
                    S_LONG: begin
                        if (w_fall) begin
                            r_state <= S_IDLE;
`ifdef BTN_DEB_REPEAT_EN
                        end else if (r_hold == C_REP_LAST) begin
                            r_repeat <= 1'b1;
                            r_hold   <= '0;
                        end else begin
                            r_hold   <= r_hold + 1'b1;
`endif
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end

        assign o_level[n]   = r_level;
        assign o_press[n]   = r_press;
        assign o_release[n] = r_release;
        assign o_long[n]    = r_long;
`ifdef BTN_DEB_REPEAT_EN
        assign o_repeat[n]  = r_repeat;
`endif
    end

`ifndef BTN_DEB_REPEAT_EN
    assign o_repeat = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_btn_deb_multi_sv.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_deb_multi_sv
// Purpose  : Scoreboard bench for btn_deb_multi_sv (active-high and
//            active-low instances) against a timestamp-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_deb_multi_sv;

    localparam int NB   = 4;
    localparam int DEB  = 4;
    localparam int LONG = 10;
    localparam int REP  = 3;
`ifdef BTN_DEB_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [NB-1:0] btn;
    logic [NB-1:0] btn_lo;
    logic [NB-1:0] lvl, prs, rel, lng, rpt;
    logic [NB-1:0] lvl_lo, prs_lo, rel_lo, lng_lo, rpt_lo;

    int tests = 0;
    int fails = 0;

    logic [39:0] sb[$];
    logic [39:0] act;
    assign act = {rpt_lo, lng_lo, rel_lo, prs_lo, lvl_lo, rpt, lng, rel, prs, lvl};

    btn_deb_multi_sv #(
        .NUM_BTN(NB), .DEB_CNT(DEB), .ACTIVE_HIGH_BTN(1'b1),
        .LONG_CNT(LONG), .REPEAT_CNT(REP)
    ) dut (
        .i_sysclk_40(clk), .i_rst(rst), .i_btn(btn),
        .o_level(lvl), .o_press(prs), .o_release(rel),
        .o_long(lng), .o_repeat(rpt)
    );

    btn_deb_multi_sv #(
        .NUM_BTN(NB), .DEB_CNT(DEB), .ACTIVE_HIGH_BTN(1'b0),
        .LONG_CNT(LONG), .REPEAT_CNT(REP)
    ) dut_lo (
        .i_sysclk_40(clk), .i_rst(rst), .i_btn(btn_lo),
        .o_level(lvl_lo), .o_press(prs_lo), .o_release(rel_lo),
        .o_long(lng_lo), .o_repeat(rpt_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a level change is accepted DEB edges after the
    // synchronized input last changed, provided it still differs; long and
    // repeat pulses are pure arithmetic on the time since the press.
    initial begin
        int t;
        int m_s1[2][NB], m_s2[2][NB], m_lvl[2][NB], m_lc[2][NB], m_pt[2][NB];
        logic [39:0] e;
        t = 0;
        forever begin
            @(posedge clk);
            t++;
            e = '0;
            for (int c = 0; c < 2; c++) begin
                for (int n = 0; n < NB; n++) begin
                    int raw, d;
                    raw = (c == 0) ? int'(btn[n]) : int'(!btn_lo[n]);
                    if (rst) begin
                        m_s1[c][n] = 0; m_s2[c][n] = 0; m_lvl[c][n] = 0;
                        m_lc[c][n] = t; m_pt[c][n] = -1000000;
                    end else begin
                        if (m_s2[c][n] != m_lvl[c][n] && (t - m_lc[c][n]) >= DEB) begin
                            if (m_lvl[c][n] == 0) begin
                                e[c*20 + 4 + n] = 1'b1;
                                m_pt[c][n] = t;
                            end else begin
                                e[c*20 + 8 + n] = 1'b1;
                            end
                            m_lvl[c][n] = 1 - m_lvl[c][n];
                        end
                        if (m_s1[c][n] != m_s2[c][n]) m_lc[c][n] = t;
                        m_s2[c][n] = m_s1[c][n];
                        m_s1[c][n] = raw;
                        d = t - m_pt[c][n];
                        e[c*20 + n] = (m_lvl[c][n] == 1);
                        e[c*20 + 12 + n] = (m_lvl[c][n] == 1) && (d == LONG);
                        e[c*20 + 16 + n] = REP_EN && (m_lvl[c][n] == 1) && (d > LONG)
                                           && (((d - LONG) % REP) == 0);
                    end
                end
            end
            sb.push_back(e);
        end
    end

    // Monitor: compare every presented output set against the scoreboard.
    initial begin
        logic [39:0] e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                tests++;
                if (act !== e) begin
                    fails++;
                    $display("FAIL outputs t=%0t act=%h exp=%h (fields rep,long,rel,press,lvl; lo instance high half)",
                             $time, act, e);
                end
            end
        end
    end

    task automatic wait_cyc(input int k);
        repeat (k) @(negedge clk);
        #1;
    endtask

    task automatic pulse_reset(input bit check_now);
        rst = 1'b1;
        #1;
        if (check_now) begin
            tests++;
            if (act !== 40'h0) begin
                fails++;
                $display("FAIL async_reset act=%h exp=%h", act, 40'h0);
            end
        end
        wait_cyc(2);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold_cnt[2][NB];
        rst    = 1'b1;
        btn    = '0;
        btn_lo = '1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(5);

        // Clean press/release on channel 0
        btn[0] = 1'b1; wait_cyc(12);
        btn[0] = 1'b0; wait_cyc(12);

        // Bouncing channel 1, never stable long enough
        for (int i = 0; i < 10; i++) begin
            btn[1] = ~btn[1];
            wait_cyc(2);
        end
        btn[1] = 1'b0; wait_cyc(10);

        // Long hold on channel 2
        btn[2] = 1'b1; wait_cyc(30);
        btn[2] = 1'b0; wait_cyc(12);

        // Simultaneous presses on channels 0 and 3
        btn = 4'b1001; wait_cyc(12);
        btn = 4'b0000; wait_cyc(12);

        // Reset while channel 2 is in long-press state
        btn[2] = 1'b1; wait_cyc(20);
        pulse_reset(1'b1);
        wait_cyc(15);
        btn[2] = 1'b0; wait_cyc(12);

        // Active-low instance press on channel 0
        btn_lo[0] = 1'b0; wait_cyc(12);
        btn_lo[0] = 1'b1; wait_cyc(12);

        // Randomized hold/bounce durations on all channels of both instances
        for (int c = 0; c < 2; c++)
            for (int n = 0; n < NB; n++)
                hold_cnt[c][n] = int'($urandom_range(1, 30));
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int n = 0; n < NB; n++) begin
                if (hold_cnt[0][n] == 0) begin
                    btn[n] = ~btn[n];
                    hold_cnt[0][n] = int'($urandom_range(1, 30));
                end else begin
                    hold_cnt[0][n]--;
                end
                if (hold_cnt[1][n] == 0) begin
                    btn_lo[n] = ~btn_lo[n];
                    hold_cnt[1][n] = int'($urandom_range(1, 30));
                end else begin
                    hold_cnt[1][n]--;
                end
            end
            if (cyc == 300) pulse_reset(1'b0);
            else wait_cyc(1);
        end

        btn    = '0;
        btn_lo = '1;
        wait_cyc(20);

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain act=%0d exp=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
